control_staticisor: RTL and testbench
=====================================

# control_staticisor

Serial-to-parallel instruction staticisor for the machine's control section. It captures the line-address and function digits of the present instruction (PI) word as they stream past during the instruction-gated scan beat. It then transfers them to the line staticisor (b_LST) and function staticisor (b_FST) on the action trigger. It sits downstream of the instruction-gate / Y-plate generator, whose gate and trigger it consumes, and upstream of the stop unit and store addressing, which consume b_FST and b_LST.

## Interface
Parameters:
- WORD_BITS, 32, digits per store word (one digit per ready cycle)
- LINE_BITS, 5, line-address digits, captured from digit 0 upward
- FUNC_LO, 13, first function digit position
- INSTR_FUNCTION_BITS, 6, function digits (matches the stop unit)
- FST_RESET, all ones, b_FST reset value; must differ from INST_HLT so reset never reads as halt

Ports (one clock; reset is asynchronous and active-high):
- w_CLK  in  1  system clock
- w_RST  in  1  asynchronous active-high reset
- ready  in  1  digit-time enable; all state frozen when low
- w_S1  in  1  bar-start marker; digit counter resynchronises
- w_INSTR_GATE  in  1  high while PI digits are valid for capture
- w_ACTION_TRIGGER_AUTO  in  1  action trigger; rising edge transfers
- w_PI  in  1  serial PI word, digit 0 (LSB) first
- b_LST  out  [0:LINE_BITS-1]  line staticisor
- b_FST  out  [0:INSTR_FUNCTION_BITS-1]  function staticisor
- w_STAT_VALID  out  1  one-cycle pulse when staticisors update

## Operation
- Digit counter is $clog2(WORD_BITS) wide and advances once per ready cycle. It wraps from WORD_BITS-1 to 0.
- w_S1 high on a ready cycle forces the next count to 1, so the S1 cycle itself is digit 0.
- Capture FSM states:
  - IDLE -> LINE when the gate is high at digit 0.
  - LINE shifts w_PI into the line shadow, digit d into bit d. At d = LINE_BITS-1 it moves to WAIT_F.
  - WAIT_F moves to FUNC at digit FUNC_LO.
  - FUNC shifts into the function shadow, bit d-FUNC_LO. At the last function digit it sets pending and returns to IDLE.
- Gate low in LINE, WAIT_F or FUNC aborts: the shadow is discarded, pending is unchanged, and the FSM returns to IDLE.
- w_S1 mid-capture restarts the capture from LINE if the gate is high, otherwise from IDLE.
- A completed capture while pending is already set overwrites the shadow (latest wins).
- Trigger edge detect registers w_ACTION_TRIGGER_AUTO each ready cycle. A rising edge with pending set (value at the start of the cycle) does the following:
  - copies the shadow to b_LST and b_FST;
  - clears pending;
  - pulses w_STAT_VALID.
- A rising edge with pending clear does nothing, and the outputs hold.
- Capture completing on the same cycle as a trigger edge is not transferred until the next edge.

## Timing
- All outputs are registered and update only on ready cycles.
- Reset values: b_LST = 0, b_FST = FST_RESET, w_STAT_VALID = 0. The FSM goes to IDLE, the counter to 0, and pending and the edge register clear.
- Reset asserted mid-capture or mid-transfer takes effect immediately (asynchronous) and discards partial state. The first capture after release needs w_S1 or a counter wrap to digit 0.
- Transfer latency: b_LST, b_FST and w_STAT_VALID change on the clock edge after the cycle in which the trigger is first sampled high.
- w_STAT_VALID is high for exactly one ready cycle and is forced low on non-ready cycles.
- The counter resynchronises on w_S1.

## Structure
- The shared timing package holds:
  - WORD_BITS, LINE_BITS, FUNC_LO and INSTR_FUNCTION_BITS;
  - INST_HLT;
  - the capture FSM state enum (IDLE, LINE, WAIT_F, FUNC).
- One natural sub-module, digit_counter: a counter with w_S1 resync and wrap, reused by other serial stages.

## Test plan
- Gate high, PI word with line bits 10110 and function bits 000001; then a trigger rising edge -> b_LST = 5'b10110 (bit0 = 1), b_FST = 6'b000001, and w_STAT_VALID pulses once, one cycle after the edge.
- Gate dropped at digit 14 -> no transfer on the trigger edge; outputs keep their previous values and w_STAT_VALID stays 0.
- Two complete captures (first function 000010, then 000011) before one trigger -> b_FST = 000011; a second trigger with no new capture does not pulse.
- ready held low for 5 cycles mid-capture, then resumed -> the captured word is identical to the uninterrupted case.
- w_RST pulsed during FUNC, with no clock edge -> outputs at reset values immediately; b_FST = 111111, not INST_HLT.
- Capture completes on the same cycle the trigger rises -> no update; the next trigger edge transfers the word.

Source files
------------

// File: rtl/control_staticisor_pkg.sv
// control_staticisor_pkg: shared serial timing constants and capture FSM states
package control_staticisor_pkg;
  localparam int WORD_BITS = 32;
  localparam int LINE_BITS = 5;
  localparam int FUNC_LO = 13;
  localparam int INSTR_FUNCTION_BITS = 6;
  localparam logic [0:INSTR_FUNCTION_BITS-1] INST_HLT = 6'b001110;
  typedef enum logic [1:0] {IDLE, LINE, WAIT_F, FUNC} state_t;
endpackage

// File: rtl/control_staticisor_digit_counter.sv
// digit_counter: per-ready digit counter with bar-start resync; the S1 cycle reads as digit 0
module digit_counter #(
  parameter int WORD_BITS = 32,
  localparam int CW = $clog2(WORD_BITS)
) (
  input  logic          w_CLK,
  input  logic          w_RST,
  input  logic          ready,
  input  logic          w_S1,
  output logic [CW-1:0] digit
);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);
  logic [CW-1:0] cnt;
  assign digit = w_S1 ? '0 : cnt;
  always_ff @(posedge w_CLK or posedge w_RST)
    if (w_RST) cnt <= '0;
    else if (ready) cnt <= w_S1 ? CW'(1) : cnt == LAST ? '0 : cnt + 1'b1;
endmodule

// File: rtl/control_staticisor.sv
// control_staticisor: captures PI line/function digits serially and staticises them on the action trigger
module control_staticisor #(
  parameter int WORD_BITS = control_staticisor_pkg::WORD_BITS,
  parameter int LINE_BITS = control_staticisor_pkg::LINE_BITS,
  parameter int FUNC_LO = control_staticisor_pkg::FUNC_LO,
  parameter int INSTR_FUNCTION_BITS = control_staticisor_pkg::INSTR_FUNCTION_BITS,
  parameter logic [0:INSTR_FUNCTION_BITS-1] FST_RESET = '1
) (
  input  logic                           w_CLK,
  input  logic                           w_RST,
  input  logic                           ready,
  input  logic                           w_S1,
  input  logic                           w_INSTR_GATE,
  input  logic                           w_ACTION_TRIGGER_AUTO,
  input  logic                           w_PI,
  output logic [0:LINE_BITS-1]           b_LST,
  output logic [0:INSTR_FUNCTION_BITS-1] b_FST,
  output logic                           w_STAT_VALID
);
  import control_staticisor_pkg::*;
  localparam int CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] D_LINE_END = CW'(LINE_BITS - 1);
  localparam logic [CW-1:0] D_FUNC_LO = CW'(FUNC_LO);
  localparam logic [CW-1:0] D_FUNC_END = CW'(FUNC_LO + INSTR_FUNCTION_BITS - 1);
  logic [CW-1:0] digit;
  state_t state, state_nxt;
  logic [0:LINE_BITS-1] line_w, line_s;
  logic [0:INSTR_FUNCTION_BITS-1] func_w, func_s, func_nxt;
  logic sh_line, sh_func, done, trig_q, pending, xfer;
  digit_counter #(.WORD_BITS(WORD_BITS)) u_digit_counter (
    .w_CLK(w_CLK),
    .w_RST(w_RST),
    .ready(ready),
    .w_S1(w_S1),
    .digit(digit)
  );
  assign func_nxt = {func_w[1:INSTR_FUNCTION_BITS-1], w_PI};
  assign xfer = w_ACTION_TRIGGER_AUTO & ~trig_q & pending;
  // Digits arrive in order, so shifting in at the top lands digit 0 in bit 0.
  always_comb begin
    state_nxt = state;
    sh_line = 1'b0;
    sh_func = 1'b0;
    done = 1'b0;
    if (!w_INSTR_GATE) state_nxt = IDLE;
    else if (digit == '0) begin
      state_nxt = LINE;
      sh_line = 1'b1;
    end else if (state == LINE) begin
      sh_line = 1'b1;
      state_nxt = digit == D_LINE_END ? WAIT_F : LINE;
    end else if (state == WAIT_F) begin
      sh_func = digit == D_FUNC_LO;
      state_nxt = sh_func ? FUNC : WAIT_F;
    end else if (state == FUNC) begin
      sh_func = 1'b1;
      done = digit == D_FUNC_END;
      state_nxt = done ? IDLE : FUNC;
    end
  end
  always_ff @(posedge w_CLK or posedge w_RST)
    if (w_RST) state <= IDLE;
    else if (ready) state <= state_nxt;
  // Working registers absorb partial captures; the shadow only changes on a complete word.
  always_ff @(posedge w_CLK or posedge w_RST)
    if (w_RST) begin
      line_w <= '0;
      func_w <= '0;
      line_s <= '0;
      func_s <= FST_RESET;
      pending <= 1'b0;
      trig_q <= 1'b0;
      b_LST <= '0;
      b_FST <= FST_RESET;
      w_STAT_VALID <= 1'b0;
    end else begin
      w_STAT_VALID <= ready & xfer;
      if (ready) begin
        trig_q <= w_ACTION_TRIGGER_AUTO;
        pending <= done | (pending & ~xfer);
        if (sh_line) line_w <= {line_w[1:LINE_BITS-1], w_PI};
        if (sh_func) func_w <= func_nxt;
        if (done) begin
          line_s <= line_w;
          func_s <= func_nxt;
        end
        if (xfer) begin
          b_LST <= line_s;
          b_FST <= func_s;
        end
      end
    end
endmodule

// File: tb/tb_control_staticisor.sv
// tb_control_staticisor: directed vector table plus hand sequences for stall, reset and trigger races
module tb_control_staticisor;
  logic w_CLK, w_RST, ready, w_S1, w_INSTR_GATE, w_ACTION_TRIGGER_AUTO, w_PI;
  logic [0:4] b_LST;
  logic [0:5] b_FST;
  logic w_STAT_VALID;
  int total = 0, bad = 0, vcount = 0;
  logic v_edge;
  control_staticisor dut (
    .w_CLK(w_CLK),
    .w_RST(w_RST),
    .ready(ready),
    .w_S1(w_S1),
    .w_INSTR_GATE(w_INSTR_GATE),
    .w_ACTION_TRIGGER_AUTO(w_ACTION_TRIGGER_AUTO),
    .w_PI(w_PI),
    .b_LST(b_LST),
    .b_FST(b_FST),
    .w_STAT_VALID(w_STAT_VALID)
  );
  initial w_CLK = 1'b0;
  always #5 w_CLK = ~w_CLK;
  always @(negedge w_CLK) if (w_STAT_VALID) vcount++;
  typedef struct {
    logic [0:4] l;
    logic [0:5] f;
    int         gate_off;
    logic [0:4] exp_lst;
    logic [0:5] exp_fst;
    logic       exp_v;
  } vec_t;
  vec_t vecs[7];
  task automatic tick();
    @(posedge w_CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic send_word(input logic [0:4] l, input logic [0:5] f, input int gate_off,
                           input int stall_at, input int trig_at);
    for (int d = 0; d < 32; d++) begin
      if (d == stall_at) begin
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          w_S1 = 1'b0;
          w_PI = 1'($urandom);
          tick();
        end
        ready = 1'b1;
      end
      w_S1 = d == 0;
      w_INSTR_GATE = d < gate_off;
      w_PI = d < 5 ? l[d] : (d >= 13 && d < 19) ? f[d-13] : 1'($urandom);
      if (trig_at >= 0) w_ACTION_TRIGGER_AUTO = d >= trig_at;
      tick();
    end
    w_S1 = 1'b0;
    w_INSTR_GATE = 1'b0;
  endtask
  task automatic trigger();
    w_ACTION_TRIGGER_AUTO = 1'b1;
    tick();
    v_edge = w_STAT_VALID;
    w_ACTION_TRIGGER_AUTO = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    int v0;
    vecs[0] = '{5'b10110, 6'b000001, 32, 5'b10110, 6'b000001, 1'b1};
    vecs[1] = '{5'b01101, 6'b101010, 14, 5'b10110, 6'b000001, 1'b0};
    vecs[2] = '{5'b11111, 6'b110011, 32, 5'b11111, 6'b110011, 1'b1};
    vecs[3] = '{5'b00001, 6'b011110, 3, 5'b11111, 6'b110011, 1'b0};
    vecs[4] = '{5'b01010, 6'b100100, 18, 5'b11111, 6'b110011, 1'b0};
    vecs[5] = '{5'b01010, 6'b100100, 19, 5'b01010, 6'b100100, 1'b1};
    vecs[6] = '{5'b10001, 6'b000000, 32, 5'b10001, 6'b000000, 1'b1};
    w_RST = 1'b1;
    ready = 1'b1;
    w_S1 = 1'b0;
    w_INSTR_GATE = 1'b0;
    w_ACTION_TRIGGER_AUTO = 1'b0;
    w_PI = 1'b0;
    tick();
    tick();
    chk("reset_lst", b_LST, 5'b00000);
    chk("reset_fst", b_FST, 6'b111111);
    chk("reset_valid", w_STAT_VALID, 1'b0);
    w_RST = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].l, vecs[i].f, vecs[i].gate_off, -1, -1);
      v0 = vcount;
      trigger();
      chk($sformatf("vec%0d_lst", i), b_LST, vecs[i].exp_lst);
      chk($sformatf("vec%0d_fst", i), b_FST, vecs[i].exp_fst);
      chk($sformatf("vec%0d_valid_edge", i), v_edge, vecs[i].exp_v);
      chk($sformatf("vec%0d_pulses", i), vcount - v0, {31'b0, vecs[i].exp_v});
    end
    // two captures before one trigger: the latest word wins, then nothing is pending
    send_word(5'b00111, 6'b000010, 32, -1, -1);
    send_word(5'b11000, 6'b000011, 32, -1, -1);
    v0 = vcount;
    trigger();
    chk("latest_lst", b_LST, 5'b11000);
    chk("latest_fst", b_FST, 6'b000011);
    chk("latest_pulses", vcount - v0, 1);
    v0 = vcount;
    trigger();
    chk("retrigger_pulses", vcount - v0, 0);
    chk("retrigger_fst", b_FST, 6'b000011);
    // ready held low for five cycles in the middle of the function field
    v0 = vcount;
    send_word(5'b10011, 6'b110101, 32, 15, -1);
    chk("stall_no_pulse", vcount - v0, 0);
    trigger();
    chk("stall_lst", b_LST, 5'b10011);
    chk("stall_fst", b_FST, 6'b110101);
    chk("stall_pulses", vcount - v0, 1);
    // asynchronous reset while in the function field
    for (int d = 0; d < 16; d++) begin
      w_S1 = d == 0;
      w_INSTR_GATE = 1'b1;
      w_PI = 1'($urandom);
      tick();
    end
    w_RST = 1'b1;
    #1;
    chk("async_lst", b_LST, 5'b00000);
    chk("async_fst", b_FST, 6'b111111);
    chk("async_not_hlt", b_FST == control_staticisor_pkg::INST_HLT, 1'b0);
    chk("async_valid", w_STAT_VALID, 1'b0);
    tick();
    w_RST = 1'b0;
    w_S1 = 1'b0;
    w_INSTR_GATE = 1'b0;
    v0 = vcount;
    trigger();
    chk("post_reset_no_pulse", vcount - v0, 0);
    chk("post_reset_fst", b_FST, 6'b111111);
    send_word(5'b01100, 6'b011001, 32, -1, -1);
    trigger();
    chk("post_reset_lst", b_LST, 5'b01100);
    chk("post_reset_capture_fst", b_FST, 6'b011001);
    // trigger rises on the very cycle the capture completes
    v0 = vcount;
    send_word(5'b11010, 6'b101101, 32, -1, 18);
    chk("race_no_pulse", vcount - v0, 0);
    chk("race_hold_lst", b_LST, 5'b01100);
    w_ACTION_TRIGGER_AUTO = 1'b0;
    tick();
    trigger();
    chk("race_next_lst", b_LST, 5'b11010);
    chk("race_next_fst", b_FST, 6'b101101);
    chk("race_next_pulses", vcount - v0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
